// File: rtl/ac97_cmd_queue.sv
// AC97 codec register-access engine: queues user read/write requests, issues one per frame
// on the slot-1/2 command inputs, and returns read data (or a timeout) from the status slots.
module ac97_cmd_queue #(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_FRAMES = 4
) (
   input  logic                     system_clock,
   input  logic                     reset,
   input  logic                     ready,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [6:0]               req_addr,
   input  logic [15:0]              req_data,
   output logic [7:0]               command_address,
   output logic [15:0]              command_data,
   output logic                     command_valid,
   input  logic                     status_valid,
   input  logic [6:0]               status_addr,
   input  logic [15:0]              status_data,
   output logic                     rsp_valid,
   output logic [6:0]               rsp_addr,
   output logic [15:0]              rsp_data,
   output logic                     rsp_timeout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [LW-1:0] LVL_ONE   = LW'(1);
   localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [7:0]    CNT_LAST  = 8'(TIMEOUT_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_t;

   logic              ready_meta_r, ready_sync_r, ready_prev_r;
   logic              tick_s;
   logic [23:0]       mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]     level_r, level_next_s;
   logic              req_ready_r, busy_r;
   state_t            state_r, state_next_s;
   logic              cur_write_r;
   logic [6:0]        pend_addr_r;
   logic [7:0]        frame_cnt_r;
   logic [7:0]        cmd_addr_r;
   logic [15:0]       cmd_data_r;
   logic              cmd_valid_r;
   logic              rsp_valid_r, rsp_timeout_r;
   logic [6:0]        rsp_addr_r;
   logic [15:0]       rsp_data_r;
   logic              push_s, pop_s, load_s, clear_cmd_s;
   logic              cnt_clear_s, cnt_inc_s, rsp_fire_s, rsp_to_s;
   logic              status_hit_s;
   logic [23:0]       head_s;

   assign tick_s       = ready_sync_r & ~ready_prev_r;
   assign push_s       = req_valid & req_ready_r;
   assign head_s       = mem_r[rd_ptr_r];
   assign status_hit_s = status_valid & (status_addr == pend_addr_r);

   assign req_ready       = req_ready_r;
   assign busy            = busy_r;
   assign level           = level_r;
   assign command_address = cmd_addr_r;
   assign command_data    = cmd_data_r;
   assign command_valid   = cmd_valid_r;
   assign rsp_valid       = rsp_valid_r;
   assign rsp_addr        = rsp_addr_r;
   assign rsp_data        = rsp_data_r;
   assign rsp_timeout     = rsp_timeout_r;

   // ready crosses from the bit-clock domain; its synchronised rising edge marks one frame
   always_ff @(posedge system_clock) begin
      if (reset) begin
         ready_meta_r <= 1'b0;
         ready_sync_r <= 1'b0;
         ready_prev_r <= 1'b0;
      end else begin
         ready_meta_r <= ready;
         ready_sync_r <= ready_meta_r;
         ready_prev_r <= ready_sync_r;
      end
   end

   // request storage; entry = {write, addr, data}
   always_ff @(posedge system_clock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {req_write, req_addr, req_data};
      end
   end

   // occupancy after this cycle's push/pop
   always_comb begin
      level_next_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + LVL_ONE;
         2'b01:   level_next_s = level_r - LVL_ONE;
         default: level_next_s = level_r;
      endcase
   end

   // next-state and control strobes; only WAIT_RD reacts outside tick cycles
   always_comb begin
      state_next_s = state_r;
      pop_s        = 1'b0;
      load_s       = 1'b0;
      clear_cmd_s  = 1'b0;
      cnt_clear_s  = 1'b0;
      cnt_inc_s    = 1'b0;
      rsp_fire_s   = 1'b0;
      rsp_to_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (tick_s) begin
               if (level_r != LVL_ZERO) begin
                  pop_s        = 1'b1;
                  load_s       = 1'b1;
                  state_next_s = ST_HOLD;
               end else begin
                  clear_cmd_s  = 1'b1;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (tick_s) begin
               if (cur_write_r) begin
                  if (level_r != LVL_ZERO) begin
                     pop_s        = 1'b1;
                     load_s       = 1'b1;
                  end else begin
                     clear_cmd_s  = 1'b1;
                     state_next_s = ST_IDLE;
                  end
               end else begin
                  clear_cmd_s  = 1'b1;
                  cnt_clear_s  = 1'b1;
                  state_next_s = ST_WAIT_RD;
               end
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         ST_WAIT_RD: begin
            // a match in the timeout tick cycle still returns real data
            if (status_hit_s) begin
               rsp_fire_s   = 1'b1;
               state_next_s = ST_IDLE;
            end else if (tick_s) begin
               if (frame_cnt_r == CNT_LAST) begin
                  rsp_fire_s   = 1'b1;
                  rsp_to_s     = 1'b1;
                  state_next_s = ST_IDLE;
               end else begin
                  cnt_inc_s    = 1'b1;
               end
            end else begin
               state_next_s = ST_WAIT_RD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // FIFO pointers, flags and FSM state
   always_ff @(posedge system_clock) begin
      if (reset) begin
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         level_r     <= LVL_ZERO;
         req_ready_r <= 1'b0;
         busy_r      <= 1'b0;
         state_r     <= ST_IDLE;
         frame_cnt_r <= 8'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r     <= level_next_s;
         req_ready_r <= (level_next_s != LVL_FULL);
         busy_r      <= (state_next_s != ST_IDLE) || (level_next_s != LVL_ZERO);
         state_r     <= state_next_s;
         if (cnt_clear_s) begin
            frame_cnt_r <= 8'd0;
         end else if (cnt_inc_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
         end
      end
   end

   // command and response output registers
   always_ff @(posedge system_clock) begin
      if (reset) begin
         cmd_addr_r    <= 8'h00;
         cmd_data_r    <= 16'h0000;
         cmd_valid_r   <= 1'b0;
         cur_write_r   <= 1'b0;
         pend_addr_r   <= 7'h00;
         rsp_valid_r   <= 1'b0;
         rsp_addr_r    <= 7'h00;
         rsp_data_r    <= 16'h0000;
         rsp_timeout_r <= 1'b0;
      end else begin
         if (load_s) begin
            cmd_addr_r  <= {~head_s[23], head_s[22:16]};
            cmd_data_r  <= head_s[23] ? head_s[15:0] : 16'h0000;
            cmd_valid_r <= 1'b1;
            cur_write_r <= head_s[23];
            pend_addr_r <= head_s[22:16];
         end else if (clear_cmd_s) begin
            cmd_valid_r <= 1'b0;
         end
         rsp_valid_r <= rsp_fire_s;
         if (rsp_fire_s) begin
            rsp_addr_r    <= pend_addr_r;
            rsp_data_r    <= rsp_to_s ? 16'h0000 : status_data;
            rsp_timeout_r <= rsp_to_s;
         end
      end
   end

endmodule

// File: tb/tb_ac97_cmd_queue.sv
// Directed bench for ac97_cmd_queue: a vector table of single requests plus
// hand-written sequences for queuing, read timeout, overflow and reset-abort.
module tb_ac97_cmd_queue;

   logic        system_clock = 1'b0;
   logic        reset, ready, req_valid, req_ready, req_write;
   logic [6:0]  req_addr, status_addr, rsp_addr;
   logic [15:0] req_data, status_data, rsp_data, command_data;
   logic [7:0]  command_address;
   logic        command_valid, status_valid, rsp_valid, rsp_timeout, busy;
   logic [3:0]  level;

   int total = 0;
   int bad   = 0;
   int rsp_seen = 0;
   int saved;

   typedef struct {
      logic        wr;
      logic [6:0]  addr;
      logic [15:0] data;
      logic [7:0]  exp_caddr;
      logic [15:0] exp_cdata;
   } vec_t;

   vec_t vecs [5];

   ac97_cmd_queue #(.DEPTH(8), .TIMEOUT_FRAMES(4)) dut (
      .system_clock(system_clock), .reset(reset), .ready(ready),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data),
      .command_address(command_address), .command_data(command_data),
      .command_valid(command_valid),
      .status_valid(status_valid), .status_addr(status_addr), .status_data(status_data),
      .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout), .level(level), .busy(busy)
   );

   always #5 system_clock = ~system_clock;

   always @(posedge system_clock) begin
      if (rsp_valid) rsp_seen <= rsp_seen + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic w, input logic [6:0] a, input logic [15:0] d);
      req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
      @(negedge system_clock);
      req_valid = 1'b0;
   endtask

   task automatic frame();
      ready = 1'b1;
      repeat (3) @(negedge system_clock);
      ready = 1'b0;
      repeat (3) @(negedge system_clock);
   endtask

   // status pulse placed exactly in the tick cycle of this frame
   task automatic frame_status(input logic [6:0] a, input logic [15:0] d);
      ready = 1'b1;
      repeat (2) @(negedge system_clock);
      status_valid = 1'b1; status_addr = a; status_data = d;
      @(negedge system_clock);
      status_valid = 1'b0;
      ready = 1'b0;
      repeat (3) @(negedge system_clock);
   endtask

   task automatic status_pulse(input logic [6:0] a, input logic [15:0] d);
      status_valid = 1'b1; status_addr = a; status_data = d;
      @(negedge system_clock);
      status_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 7'h02, 16'h0808, 8'h02, 16'h0808};
      vecs[1] = '{1'b0, 7'h7C, 16'h4144, 8'hFC, 16'h0000};
      vecs[2] = '{1'b1, 7'h7F, 16'hFFFF, 8'h7F, 16'hFFFF};
      vecs[3] = '{1'b0, 7'h00, 16'hA5A5, 8'h80, 16'h0000};
      vecs[4] = '{1'b1, 7'h55, 16'h1234, 8'h55, 16'h1234};

      reset = 1'b1; ready = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = 7'h00; req_data = 16'h0000;
      status_valid = 1'b0; status_addr = 7'h00; status_data = 16'h0000;
      repeat (3) @(negedge system_clock);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_cmd_valid", 32'(command_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      reset = 1'b0;
      @(negedge system_clock);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // vector table: one request each, issued and retired
      for (int i = 0; i < 5; i++) begin
         push(vecs[i].wr, vecs[i].addr, vecs[i].data);
         check("vec_level_push", 32'(level), 32'd1);
         frame();
         check("vec_cmd_addr", 32'(command_address), 32'(vecs[i].exp_caddr));
         check("vec_cmd_data", 32'(command_data), 32'(vecs[i].exp_cdata));
         check("vec_cmd_valid", 32'(command_valid), 32'd1);
         check("vec_level_pop", 32'(level), 32'd0);
         frame();
         check("vec_cmd_clear", 32'(command_valid), 32'd0);
         if (vecs[i].wr) begin
            check("vec_wr_busy", 32'(busy), 32'd0);
         end else begin
            check("vec_rd_busy", 32'(busy), 32'd1);
            status_pulse(vecs[i].addr, vecs[i].data);
            check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            check("vec_rsp_addr", 32'(rsp_addr), 32'(vecs[i].addr));
            check("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].data));
            check("vec_rsp_to", 32'(rsp_timeout), 32'd0);
            @(negedge system_clock);
            check("vec_rsp_pulse", 32'(rsp_valid), 32'd0);
            check("vec_rd_idle", 32'(busy), 32'd0);
         end
      end

      // three queued writes, back to back
      push(1'b1, 7'h10, 16'h1111);
      push(1'b1, 7'h12, 16'h2222);
      push(1'b1, 7'h14, 16'h3333);
      check("q3_level", 32'(level), 32'd3);
      frame();
      check("q3_a0", 32'(command_address), 32'h10);
      check("q3_v0", 32'(command_valid), 32'd1);
      check("q3_l0", 32'(level), 32'd2);
      frame();
      check("q3_a1", 32'(command_data), 32'h2222);
      check("q3_v1", 32'(command_valid), 32'd1);
      check("q3_l1", 32'(level), 32'd1);
      frame();
      check("q3_a2", 32'(command_address), 32'h14);
      check("q3_v2", 32'(command_valid), 32'd1);
      check("q3_l2", 32'(level), 32'd0);
      frame();
      check("q3_clear", 32'(command_valid), 32'd0);

      // read answered two frames after entering WAIT_RD
      push(1'b0, 7'h7C, 16'hFFFF);
      frame();
      check("rd_caddr", 32'(command_address), 32'hFC);
      check("rd_cdata", 32'(command_data), 32'h0);
      frame();
      frame();
      frame();
      check("rd_wait_busy", 32'(busy), 32'd1);
      status_pulse(7'h7C, 16'h4144);
      check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rd_rsp_data", 32'(rsp_data), 32'h4144);
      check("rd_rsp_to", 32'(rsp_timeout), 32'd0);

      // read timeout with an unrelated status in between
      @(negedge system_clock);
      push(1'b0, 7'h26, 16'h0000);
      frame();
      frame();
      saved = rsp_seen;
      status_pulse(7'h24, 16'hDEAD);
      check("to_nomatch", 32'(rsp_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         frame();
         check("to_early", 32'(rsp_seen), 32'(saved));
      end
      frame();
      check("to_count", 32'(rsp_seen), 32'(saved + 1));
      check("to_flag", 32'(rsp_timeout), 32'd1);
      check("to_data", 32'(rsp_data), 32'h0);
      check("to_addr", 32'(rsp_addr), 32'h26);
      check("to_idle", 32'(busy), 32'd0);

      // match in the same cycle as the timeout tick
      push(1'b0, 7'h33, 16'h0000);
      frame();
      frame();
      frame(); frame(); frame();
      saved = rsp_seen;
      frame_status(7'h33, 16'h5A5A);
      check("mw_count", 32'(rsp_seen), 32'(saved + 1));
      check("mw_to", 32'(rsp_timeout), 32'd0);
      check("mw_data", 32'(rsp_data), 32'h5A5A);

      // overflow: nine pushes, no ticks
      for (int i = 0; i < 8; i++) push(1'b1, 7'(16 + i), 16'(16'h1000 + i));
      check("ov_level", 32'(level), 32'd8);
      check("ov_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h3F; req_data = 16'hBEEF;
      @(negedge system_clock);
      check("ov_reject", 32'(level), 32'd8);
      ready = 1'b1;
      repeat (3) @(negedge system_clock);
      check("ov_pop_addr", 32'(command_address), 32'h10);
      check("ov_pop_level", 32'(level), 32'd7);
      check("ov_pop_ready", 32'(req_ready), 32'd1);
      @(negedge system_clock);
      req_valid = 1'b0;
      check("ov_accept", 32'(level), 32'd8);
      ready = 1'b0;
      repeat (3) @(negedge system_clock);
      for (int i = 1; i < 8; i++) begin
         frame();
         check("ov_order", 32'(command_address), 32'(16 + i));
      end
      frame();
      check("ov_ninth_addr", 32'(command_address), 32'h3F);
      check("ov_ninth_data", 32'(command_data), 32'hBEEF);
      frame();
      check("ov_drained", 32'(command_valid), 32'd0);
      check("ov_level0", 32'(level), 32'd0);

      // reset while waiting for a read with two requests queued
      push(1'b0, 7'h10, 16'h0000);
      frame();
      push(1'b1, 7'h20, 16'h0001);
      push(1'b1, 7'h21, 16'h0002);
      frame();
      check("ra_level2", 32'(level), 32'd2);
      saved = rsp_seen;
      reset = 1'b1;
      @(negedge system_clock);
      check("ra_level", 32'(level), 32'd0);
      check("ra_cmd_valid", 32'(command_valid), 32'd0);
      check("ra_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      frame_status(7'h10, 16'h1111);
      frame(); frame(); frame(); frame();
      check("ra_no_rsp", 32'(rsp_seen), 32'(saved));
      check("ra_idle_cmd", 32'(command_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
